fetch_sequencer: RTL and testbench

- Central controller for the fetch stage of the 5-stage MIPS pipeline.
- Each cycle it decides whether the PC advances, holds, or is redirected. Redirect sources are a branch or jump-register from D, an exception from M, and an eret from M.
- Drives the IF stage's PC load enable (stallf input), pcchangef and pcbranchf, plus pipeline flush strobes.
- Sequential content:
  - a pending-redirect latch for redirects that arrive while the pipeline is frozen;
  - a 2-state exception FSM;
  - saturating performance counters.

---
 rtl/fetch_sequencer.sv | 159 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: chooses PC advance, hold or redirect each cycle,
// buffers redirects that arrive during a freeze and tracks exception entry.
module fetch_sequencer #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freeze,
    input  logic             hazard_stall,
    input  logic             mdu_busy,
    input  logic             br_req,
    input  logic [31:0]      br_target,
    input  logic             jr_req,
    input  logic [31:0]      jr_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [31:0]      epc,
    output logic             pcenf,
    output logic             pcchangef,
    output logic [31:0]      pcbranchf,
    output logic             flushd,
    output logic             flushe,
    output logic             flushm,
    output logic             in_exc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redir_cnt
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_pend_valid;
    logic             r_pend_is_exc;
    logic [31:0]      r_pend_target;
    logic             w_pend_valid_nxt;
    logic             w_pend_is_exc_nxt;
    logic [31:0]      w_pend_target_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_redir_cnt;

    logic             w_pcenf;
    logic             w_pcchange;
    logic [31:0]      w_target;
    logic             w_flushd;
    logic             w_flushe;
    logic             w_flushm;

    // Per-cycle priority decision: freeze, exception, pending, eret, EXC settle, stall, branch.
    always_comb begin
        w_pcenf           = 1'b1;
        w_pcchange        = 1'b0;
        w_target          = 32'h0000_0000;
        w_flushd          = 1'b0;
        w_flushe          = 1'b0;
        w_flushm          = 1'b0;
        w_state_nxt       = r_state;
        w_pend_valid_nxt  = 1'b0;
        w_pend_is_exc_nxt = 1'b0;
        w_pend_target_nxt = 32'h0000_0000;
        if (freeze) begin
            w_pcenf = 1'b0;
            if (exc_req) begin
                w_pend_valid_nxt  = 1'b1;
                w_pend_is_exc_nxt = 1'b1;
                w_pend_target_nxt = EXC_VECTOR;
            end else if (eret_req && !r_pend_valid) begin
                w_pend_valid_nxt  = 1'b1;
                w_pend_is_exc_nxt = 1'b0;
                w_pend_target_nxt = epc;
            end else begin
                w_pend_valid_nxt  = r_pend_valid;
                w_pend_is_exc_nxt = r_pend_is_exc;
                w_pend_target_nxt = r_pend_target;
            end
        end else if (exc_req || (r_pend_valid && r_pend_is_exc)) begin
            w_pcchange  = 1'b1;
            w_target    = EXC_VECTOR;
            w_flushd    = 1'b1;
            w_flushe    = 1'b1;
            w_flushm    = 1'b1;
            w_state_nxt = ST_EXC;
        end else if (r_pend_valid || eret_req) begin
            // A buffered eret takes precedence over a live one in the same cycle.
            w_pcchange  = 1'b1;
            w_target    = r_pend_valid ? r_pend_target : epc;
            w_flushd    = 1'b1;
            w_flushe    = 1'b1;
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_EXC) begin
            w_pcenf     = 1'b0;
            w_flushd    = 1'b1;
            w_state_nxt = ST_RUN;
        end else if (hazard_stall || mdu_busy) begin
            w_pcenf = 1'b0;
        end else if (br_req) begin
            w_pcchange = 1'b1;
            w_target   = br_target;
        end else if (jr_req) begin
            w_pcchange = 1'b1;
            w_target   = jr_target;
        end else begin
            w_pcenf = 1'b1;
        end
    end

    // State, pending-redirect latch and saturating counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_pend_valid  <= 1'b0;
            r_pend_is_exc <= 1'b0;
            r_pend_target <= 32'h0000_0000;
            r_stall_cnt   <= {CNT_W{1'b0}};
            r_redir_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_is_exc <= w_pend_is_exc_nxt;
            r_pend_target <= w_pend_target_nxt;
            if (!w_pcenf) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_pcchange) begin
                r_redir_cnt <= sat_inc(r_redir_cnt);
            end else begin
                r_redir_cnt <= r_redir_cnt;
            end
        end
    end

    assign pcenf     = reset & w_pcenf;
    assign pcchangef = reset & w_pcchange;
    assign pcbranchf = reset ? w_target : 32'h0000_0000;
    assign flushd    = reset & w_flushd;
    assign flushe    = reset & w_flushe;
    assign flushm    = reset & w_flushm;
    assign in_exc    = reset & (r_state == ST_EXC);
    assign stall_cnt = reset ? r_stall_cnt : {CNT_W{1'b0}};
    assign redir_cnt = reset ? r_redir_cnt : {CNT_W{1'b0}};

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a priority-rule model queues the expected
// outputs per cycle, and a monitor on the falling edge compares them.
module tb_fetch_sequencer;

    localparam int          CW   = 4;
    localparam logic [31:0] EVEC = 32'h0000_4180;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, freeze, hazard_stall, mdu_busy, br_req, jr_req, exc_req, eret_req;
    logic [31:0]   br_target, jr_target, epc;
    logic          pcenf, pcchangef, flushd, flushe, flushm, in_exc;
    logic [31:0]   pcbranchf;
    logic [CW-1:0] stall_cnt, redir_cnt;

    fetch_sequencer #(.EXC_VECTOR(EVEC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .freeze(freeze), .hazard_stall(hazard_stall),
        .mdu_busy(mdu_busy), .br_req(br_req), .br_target(br_target), .jr_req(jr_req),
        .jr_target(jr_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .pcenf(pcenf), .pcchangef(pcchangef), .pcbranchf(pcbranchf), .flushd(flushd),
        .flushe(flushe), .flushm(flushm), .in_exc(in_exc), .stall_cnt(stall_cnt),
        .redir_cnt(redir_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pcenf, pcchg, fd, fe, fm, inexc;
        logic [31:0] pcbr;
        int          scnt, rcnt;
    } exp_t;

    typedef struct {
        bit          is_exc;
        logic [31:0] tgt;
    } pend_t;

    exp_t  exp_q[$];
    pend_t m_pend[$];
    bit    m_exc;
    int    m_scnt, m_rcnt;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
        end
    endtask

    // Reference: apply the priority rules to the current inputs, queue the expected view,
    // then advance the model across the coming clock edge.
    task automatic model_cycle();
        exp_t  e;
        pend_t p;
        e = '{pcenf: 1'b0, pcchg: 1'b0, fd: 1'b0, fe: 1'b0, fm: 1'b0, inexc: 1'b0,
              pcbr: 32'h0, scnt: 0, rcnt: 0};
        if (!reset) begin
            m_exc = 1'b0;
            m_pend.delete();
            m_scnt = 0;
            m_rcnt = 0;
            exp_q.push_back(e);
            return;
        end
        e.inexc = m_exc;
        e.scnt  = m_scnt;
        e.rcnt  = m_rcnt;
        e.pcenf = 1'b1;
        if (freeze) begin
            e.pcenf = 1'b0;
            if (exc_req) begin
                m_pend.delete();
                p = '{is_exc: 1'b1, tgt: EVEC};
                m_pend.push_back(p);
            end else if (eret_req && m_pend.size() == 0) begin
                p = '{is_exc: 1'b0, tgt: epc};
                m_pend.push_back(p);
            end
        end else if (exc_req || (m_pend.size() > 0 && m_pend[0].is_exc)) begin
            e.pcchg = 1'b1; e.pcbr = EVEC;
            e.fd = 1'b1; e.fe = 1'b1; e.fm = 1'b1;
            m_exc = 1'b1;
            m_pend.delete();
        end else if (m_pend.size() > 0 || eret_req) begin
            e.pcchg = 1'b1;
            e.pcbr  = (m_pend.size() > 0) ? m_pend[0].tgt : epc;
            e.fd = 1'b1; e.fe = 1'b1;
            m_exc = 1'b0;
            m_pend.delete();
        end else if (m_exc) begin
            e.pcenf = 1'b0; e.fd = 1'b1;
            m_exc = 1'b0;
        end else if (hazard_stall || mdu_busy) begin
            e.pcenf = 1'b0;
        end else if (br_req || jr_req) begin
            e.pcchg = 1'b1;
            e.pcbr  = br_req ? br_target : jr_target;
        end
        exp_q.push_back(e);
        if (!e.pcenf) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
        if (e.pcchg)  m_rcnt = (m_rcnt < CMAX) ? m_rcnt + 1 : CMAX;
    endtask

    task automatic cyc(input logic r, input logic f, input logic h, input logic m,
                       input logic b, input logic [31:0] bt, input logic j,
                       input logic [31:0] jt, input logic x, input logic er,
                       input logic [31:0] ep);
        @(posedge clk);
        #1;
        reset = r; freeze = f; hazard_stall = h; mdu_busy = m;
        br_req = b; br_target = bt; jr_req = j; jr_target = jt;
        exc_req = x; eret_req = er; epc = ep;
        model_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Monitor: one expected entry per cycle, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pcenf",     {31'h0, pcenf},     {31'h0, e.pcenf});
                chk("pcchangef", {31'h0, pcchangef}, {31'h0, e.pcchg});
                chk("pcbranchf", pcbranchf,          e.pcbr);
                chk("flushd",    {31'h0, flushd},    {31'h0, e.fd});
                chk("flushe",    {31'h0, flushe},    {31'h0, e.fe});
                chk("flushm",    {31'h0, flushm},    {31'h0, e.fm});
                chk("in_exc",    {31'h0, in_exc},    {31'h0, e.inexc});
                chk("stall_cnt", {28'h0, stall_cnt}, e.scnt);
                chk("redir_cnt", {28'h0, redir_cnt}, e.rcnt);
            end
        end
    end

    initial begin
        int wait_cnt;
        reset = 1'b0; freeze = 1'b0; hazard_stall = 1'b0; mdu_busy = 1'b0;
        br_req = 1'b0; br_target = 32'h0; jr_req = 1'b0; jr_target = 32'h0;
        exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle(5);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3010, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(1);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3020, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3020, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3030, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3040);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(3);
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle(2);
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(99) >= 2) ? 1'b1 : 1'b0,
                ($urandom_range(99) < 15) ? 1'b1 : 1'b0,
                ($urandom_range(99) < 15) ? 1'b1 : 1'b0,
                ($urandom_range(99) < 10) ? 1'b1 : 1'b0,
                ($urandom_range(99) < 30) ? 1'b1 : 1'b0, $urandom,
                ($urandom_range(99) < 20) ? 1'b1 : 1'b0, $urandom,
                ($urandom_range(99) < 6)  ? 1'b1 : 1'b0,
                ($urandom_range(99) < 10) ? 1'b1 : 1'b0, $urandom);
        end
        idle(1);
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
